// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR digit-sequence generator.
// Holds the FSM state encoding, default tap masks and the index-width helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default feedback masks for fb = ^(r & TAPS) with a right-shifting register.
    localparam logic [3:0] TAPS_4 = 4'hD;
    localparam logic [7:0] TAPS_8 = 8'hB8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lfsr_seq_gen_if.sv
// Bus between the game FSM / display logic and the sequence generator.
// Handshake: start is sampled only while idle; busy is high from load until done; done pulses one cycle.
interface lfsr_seq_gen_if #(
    parameter int LFSR_W     = 4,
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = lfsr_pkg::idx_w(NUM_DIGITS)
);

    logic                          start;
    logic [LFSR_W-1:0]             seed;
    logic                          busy;
    logic                          done;
    logic                          seq_valid;
    logic [NUM_DIGITS*DIGIT_W-1:0] seq_flat;
    logic [IDX_W-1:0]              rd_idx;
    logic [DIGIT_W-1:0]            rd_digit;
    lfsr_pkg::state_t              state_dbg;
    logic [LFSR_W-1:0]             lfsr_dbg;

    modport master (
        output start, seed, rd_idx,
        input  busy, done, seq_valid, seq_flat, rd_digit, state_dbg, lfsr_dbg
    );

    modport slave (
        input  start, seed, rd_idx,
        output busy, done, seq_valid, seq_flat, rd_digit, state_dbg, lfsr_dbg
    );

endinterface

// File: rtl/lfsr_seq_gen_core.sv
// Fibonacci-style LFSR register: shifts right, feedback enters at the MSB.
// load has priority over step; r_next is the value the register takes on a step.
module lfsr_core #(
    parameter int                LFSR_W = 4,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(lfsr_pkg::TAPS_4)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] r_next,
    output logic [LFSR_W-1:0] r
);

    logic [LFSR_W-1:0] r_q, r_d;

    assign r_next = {^(r_q & TAPS), r_q[LFSR_W-1:1]};
    assign r      = r_q;

    always_comb begin
        r_d = r_q;
        if (load) begin
            r_d = load_val;
        end else if (step) begin
            r_d = r_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Pseudo-random digit-sequence generator: rejection-samples LFSR output into NUM_DIGITS digits.
// Define LFSR_SEQ_NO_REPEAT_EN to also reject a digit equal to the previously accepted one.
module lfsr_seq_gen
    import lfsr_pkg::*;
#(
    parameter int                LFSR_W     = 4,
    parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(TAPS_4),
    parameter int                DIGIT_W    = 4,
    parameter int                NUM_DIGITS = 4,
    parameter int                MAX_DIGIT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_seq_gen_if.slave bus
);

    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int FLAT_W = NUM_DIGITS * DIGIT_W;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [FLAT_W-1:0]   flat_q, flat_d;
    logic                seq_valid_q, seq_valid_d;
    logic                load, step, accept, repeat_ok;
    logic [LFSR_W-1:0]   r_next, r;
    logic [DIGIT_W-1:0]  cand;
    int                  wr_i, rd_i;
    logic                rd_in_range;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (seed_q),
        .step     (step),
        .r_next   (r_next),
        .r        (r)
    );

    assign cand = r_next[DIGIT_W-1:0];
    assign wr_i = int'(count_q);

`ifdef LFSR_SEQ_NO_REPEAT_EN
    int                 prev_i;
    logic [DIGIT_W-1:0] prev_digit;
    assign prev_i     = (wr_i > 0) ? wr_i - 1 : 0;
    assign prev_digit = flat_q[prev_i*DIGIT_W +: DIGIT_W];
    assign repeat_ok  = (count_q == '0) || (cand != prev_digit);
`else
    assign repeat_ok = 1'b1;
`endif

    assign accept = (state_q == ST_STEP) && (int'(cand) <= MAX_DIGIT) && repeat_ok;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        count_d     = count_q;
        flat_d      = flat_q;
        seq_valid_d = seq_valid_q;
        load        = 1'b0;
        step        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // An all-zero seed would lock the LFSR at zero forever.
                    seed_d      = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
                    seq_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                count_d = '0;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                step = 1'b1;
                if (accept) begin
                    flat_d[wr_i*DIGIT_W +: DIGIT_W] = cand;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(NUM_DIGITS - 1)) begin
                        seq_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            count_q     <= '0;
            flat_q      <= '0;
            seq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            count_q     <= count_d;
            flat_q      <= flat_d;
            seq_valid_q <= seq_valid_d;
        end
    end

    // Out-of-range read indices return zero rather than aliasing into a stored digit.
    assign rd_in_range   = int'(bus.rd_idx) < NUM_DIGITS;
    assign rd_i          = rd_in_range ? int'(bus.rd_idx) : 0;
    assign bus.rd_digit  = rd_in_range ? flat_q[rd_i*DIGIT_W +: DIGIT_W] : '0;

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.seq_valid = seq_valid_q;
    assign bus.seq_flat  = flat_q;
    assign bus.state_dbg = state_q;
    assign bus.lfsr_dbg  = r;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Bench for lfsr_seq_gen: two instances (4 digits 0..15, and 3 digits 0..9) against a reference model.
module tb_lfsr_seq_gen;
    import lfsr_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [15:0] exp_a_q[$];
    int          exp_a_cyc_q[$];
    logic [11:0] exp_b_q[$];
    int          exp_b_cyc_q[$];

    lfsr_seq_gen_if #(.LFSR_W(4), .DIGIT_W(4), .NUM_DIGITS(4)) a_if ();
    lfsr_seq_gen_if #(.LFSR_W(4), .DIGIT_W(4), .NUM_DIGITS(3)) b_if ();

    lfsr_seq_gen #(
        .LFSR_W(4), .TAPS(4'hD), .DIGIT_W(4), .NUM_DIGITS(4), .MAX_DIGIT(15)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (a_if.slave)
    );

    lfsr_seq_gen #(
        .LFSR_W(4), .TAPS(4'hD), .DIGIT_W(4), .NUM_DIGITS(3), .MAX_DIGIT(9)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b_if.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the LFSR state sequence and keep the values the rules accept.
    function automatic void model(input int sd, input int nd, input int maxd,
                                  output logic [15:0] flat, output int rej);
        int r, fb, cand, cnt, last;
        bit ok;
        r    = (sd == 0) ? 1 : sd;
        cnt  = 0;
        last = -1;
        rej  = 0;
        flat = '0;
        for (int guard = 0; guard < 1000 && cnt < nd; guard++) begin
            fb   = $countones(r & 32'hD) % 2;
            r    = (r >> 1) | (fb << 3);
            cand = r;
            ok   = (cand <= maxd);
`ifdef LFSR_SEQ_NO_REPEAT_EN
            if (cnt > 0 && cand == last) ok = 1'b0;
`endif
            if (ok) begin
                flat[cnt*4 +: 4] = 4'(cand);
                last = cand;
                cnt++;
            end else begin
                rej++;
            end
        end
    endfunction

    // ---------------- scoreboard monitors ----------------
    logic [15:0] mon_a_f;
    int          mon_a_c;
    logic [11:0] mon_b_f;
    int          mon_b_c;

    always @(negedge clk) begin
        if (a_if.done === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                chk("a_spurious_done", 32'(a_if.done), 32'd0);
            end else begin
                mon_a_f = exp_a_q.pop_front();
                mon_a_c = exp_a_cyc_q.pop_front();
                chk("a_seq_flat", 32'(a_if.seq_flat), 32'(mon_a_f));
                chk("a_done_cycle", 32'(cyc), 32'(mon_a_c));
                chk("a_valid_at_done", 32'(a_if.seq_valid), 32'd1);
                chk("a_busy_at_done", 32'(a_if.busy), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (b_if.done === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                chk("b_spurious_done", 32'(b_if.done), 32'd0);
            end else begin
                mon_b_f = exp_b_q.pop_front();
                mon_b_c = exp_b_cyc_q.pop_front();
                chk("b_seq_flat", 32'(b_if.seq_flat), 32'(mon_b_f));
                chk("b_done_cycle", 32'(cyc), 32'(mon_b_c));
                chk("b_valid_at_done", 32'(b_if.seq_valid), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_a(input int sd, input bit hammer);
        logic [15:0] f;
        int rej, e;
        model(sd, 4, 15, f, rej);
        @(negedge clk);
        a_if.start = 1'b1;
        a_if.seed  = 4'(sd);
        e = cyc + 4 + 2 + rej;
        exp_a_q.push_back(f);
        exp_a_cyc_q.push_back(e);
        @(negedge clk);
        a_if.start = 1'b0;
        chk("a_busy_after_start", 32'(a_if.busy), 32'd1);
        chk("a_valid_cleared", 32'(a_if.seq_valid), 32'd0);
        if (hammer) begin
            while (cyc < e) begin
                a_if.start = 1'($urandom_range(0, 1));
                a_if.seed  = 4'($urandom);
                @(negedge clk);
            end
            a_if.start = 1'b1;
            @(negedge clk);
            a_if.start = 1'b0;
        end
        for (int i = 0; i < 200 && exp_a_q.size() != 0; i++) @(negedge clk);
        if (exp_a_q.size() != 0) begin
            chk("a_done_timeout", 32'(exp_a_q.size()), 32'd0);
            exp_a_q.delete();
            exp_a_cyc_q.delete();
        end
        @(negedge clk);
        chk("a_busy_idle", 32'(a_if.busy), 32'd0);
        chk("a_flat_stable", 32'(a_if.seq_flat), 32'(f));
        for (int i = 0; i < 4; i++) begin
            a_if.rd_idx = 2'(i);
            #1;
            chk("a_rd_digit", 32'(a_if.rd_digit), 32'(f[i*4 +: 4]));
        end
        chk("a_valid_held", 32'(a_if.seq_valid), 32'd1);
    endtask

    task automatic run_b(input int sd);
        logic [15:0] f;
        int rej, e;
        model(sd, 3, 9, f, rej);
        @(negedge clk);
        b_if.start = 1'b1;
        b_if.seed  = 4'(sd);
        e = cyc + 3 + 2 + rej;
        exp_b_q.push_back(f[11:0]);
        exp_b_cyc_q.push_back(e);
        @(negedge clk);
        b_if.start = 1'b0;
        for (int i = 0; i < 200 && exp_b_q.size() != 0; i++) @(negedge clk);
        if (exp_b_q.size() != 0) begin
            chk("b_done_timeout", 32'(exp_b_q.size()), 32'd0);
            exp_b_q.delete();
            exp_b_cyc_q.delete();
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b_if.rd_idx = 2'(i);
            #1;
            chk("b_rd_digit", 32'(b_if.rd_digit), (i < 3) ? 32'(f[i*4 +: 4]) : 32'd0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_busy"}, 32'(a_if.busy), 32'd0);
        chk({tag, "_a_done"}, 32'(a_if.done), 32'd0);
        chk({tag, "_a_valid"}, 32'(a_if.seq_valid), 32'd0);
        chk({tag, "_a_flat"}, 32'(a_if.seq_flat), 32'd0);
        chk({tag, "_a_lfsr"}, 32'(a_if.lfsr_dbg), 32'd0);
        chk({tag, "_a_state"}, 32'(a_if.state_dbg), 32'(ST_IDLE));
        chk({tag, "_b_flat"}, 32'(b_if.seq_flat), 32'd0);
        chk({tag, "_b_valid"}, 32'(b_if.seq_valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        a_if.start = 1'b0; a_if.seed = '0; a_if.rd_idx = '0;
        b_if.start = 1'b0; b_if.seed = '0; b_if.rd_idx = '0;
        repeat (2) @(negedge clk);
        chk_reset_state("por");
        rst_n = 1'b1;

        run_a(1, 1'b0);
        chk("a_seed1_digits", 32'(a_if.seq_flat), 32'h0000_B6C8);
        run_a(0, 1'b1);
        chk("a_seed0_digits", 32'(a_if.seq_flat), 32'h0000_B6C8);

        // Reset in the middle of STEP, two digits in.
        @(negedge clk);
        a_if.start = 1'b1;
        a_if.seed  = 4'h1;
        exp_a_q.push_back(16'hB6C8);
        exp_a_cyc_q.push_back(cyc + 6);
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_mid_state", 32'(a_if.state_dbg), 32'(ST_STEP));
        chk("a_mid_partial", 32'(a_if.seq_flat[7:0]), 32'h0000_00C8);
        rst_n = 1'b0;
        #1;
        void'(exp_a_q.pop_back());
        void'(exp_a_cyc_q.pop_back());
        chk_reset_state("mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_a(1, 1'b0);
        chk("a_regen_digits", 32'(a_if.seq_flat), 32'h0000_B6C8);

        for (int n = 0; n < 8; n++) begin
            run_a(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        run_b(1);
        chk("b_seed1_digits", 32'(b_if.seq_flat), 32'h0000_0568);
        for (int n = 0; n < 6; n++) begin
            run_b(int'($urandom_range(0, 15)));
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
